hartslag_sequencer: RTL and testbench

HARTSLAG_SEQUENCER -- requirements
Module: hartslag_sequencer

---
 rtl/hartslag_sequencer.sv | 149 ++++++++++++++
 tb/tb_hartslag_sequencer.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/hartslag_sequencer.sv
// Heart-rate sequencer: synchronised, debounced beat input counted over a fixed window and reported as bpm.
// Define HARTSLAG_ALARM_EN to build the too_low/too_high comparators; otherwise both outputs are tied to 0.
module hartslag_sequencer #(
  parameter int WINDOW_CYCLES   = 50_000_000,
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int WIN_SHIFT       = 2,
  parameter int BPM_LOW         = 60,
  parameter int BPM_HIGH        = 180
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       stop,
  input  logic       cont,
  input  logic       beat_in,
  input  logic       bpm_ack,
  output logic [7:0] bpm,
  output logic       bpm_valid,
  output logic       overrun,
  output logic       busy,
  output logic       too_low,
  output logic       too_high
);

  // state   | meaning
  // IDLE    | waiting for start
  // ARM     | one cycle, clears beat and window counters
  // MEASURE | WINDOW_CYCLES cycles counting filtered rising edges
  // REPORT  | one cycle, loads bpm and alarms
  typedef enum logic [1:0] {IDLE, ARM, MEASURE, REPORT} state_t;

  localparam int WW = $clog2(WINDOW_CYCLES + 1);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int PW = (8 + WIN_SHIFT > 11) ? 8 + WIN_SHIFT : 11;

  state_t          state, state_nxt;
  logic            sync1, sync2, filt, filt_d;
  logic [DW-1:0]   deb_cnt;
  logic [WW-1:0]   win_cnt;
  logic [7:0]      beats;
  logic            cont_q;
  logic            beat_rise;
  logic            do_start, do_report;
  logic [PW-1:0]   scaled;
  logic [7:0]      bpm_new;

  // Filtered level follows sync2 only after DEBOUNCE_CYCLES consecutive differing samples.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      filt    <= 1'b0;
      filt_d  <= 1'b0;
      deb_cnt <= '0;
    end else begin
      sync1  <= beat_in;
      sync2  <= sync1;
      filt_d <= filt;
      if (sync2 == filt) begin
        deb_cnt <= '0;
      end else if (deb_cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
        filt    <= sync2;
        deb_cnt <= '0;
      end else begin
        deb_cnt <= deb_cnt + DW'(1);
      end
    end
  end

  assign beat_rise = filt & ~filt_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = ARM;
      end
      ARM:     state_nxt = MEASURE;
      MEASURE: if (win_cnt == '0) state_nxt = REPORT;
      REPORT:  state_nxt = cont_q ? ARM : IDLE;
      default: state_nxt = IDLE;
    endcase
    if (stop) state_nxt = IDLE;
  end

  assign do_start  = (state == IDLE) & start & ~stop;
  assign do_report = (state == REPORT) & ~stop;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      win_cnt <= '0;
      beats   <= '0;
      cont_q  <= 1'b0;
    end else begin
      if (do_start) cont_q <= cont;
      if (state == ARM) begin
        win_cnt <= WW'(WINDOW_CYCLES - 1);
        beats   <= '0;
      end else if (state == MEASURE) begin
        if (win_cnt != '0) win_cnt <= win_cnt - WW'(1);
        if (beat_rise && beats != 8'hFF) beats <= beats + 8'd1;
      end
    end
  end

  assign scaled  = PW'(beats) << WIN_SHIFT;
  assign bpm_new = (scaled > PW'(255)) ? 8'hFF : scaled[7:0];

  // A same-cycle ack consumes the old result, so only an unacked result raises overrun.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bpm       <= '0;
      bpm_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (do_report) begin
        bpm       <= bpm_new;
        bpm_valid <= 1'b1;
      end else if (bpm_ack) begin
        bpm_valid <= 1'b0;
      end
      if (do_report && bpm_valid && !bpm_ack) overrun <= 1'b1;
      else if (do_start)                      overrun <= 1'b0;
    end
  end

`ifdef HARTSLAG_ALARM_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      too_low  <= 1'b0;
      too_high <= 1'b0;
    end else if (do_report) begin
      too_low  <= (32'(bpm_new) < BPM_LOW);
      too_high <= (32'(bpm_new) > BPM_HIGH);
    end
  end
`else
  assign too_low  = 1'b0;
  assign too_high = 1'b0;
`endif

endmodule

// File: tb/tb_hartslag_sequencer.sv
// Self-checking bench for hartslag_sequencer: random clean/glitchy pulse trains scored by counting clean pulses.
// A second instance with a long window covers bpm saturation.
`timescale 1ns/1ps
module tb_hartslag_sequencer;
  localparam int W  = 100;
  localparam int D  = 4;
  localparam int SH = 2;
  localparam int LO = 20;
  localparam int HI = 40;
  localparam int W2 = 2000;
`ifdef HARTSLAG_ALARM_EN
  localparam bit ALARM_EN = 1'b1;
`else
  localparam bit ALARM_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset, start, stop, cont, beat_in, bpm_ack;
  logic [7:0] bpm, bpm2;
  logic bpm_valid, overrun, busy, too_low, too_high;
  logic bpm_valid2, overrun2, busy2, too_low2, too_high2;

  always #5 clk = ~clk;

  hartslag_sequencer #(.WINDOW_CYCLES(W), .DEBOUNCE_CYCLES(D), .WIN_SHIFT(SH),
                       .BPM_LOW(LO), .BPM_HIGH(HI)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .cont(cont),
    .beat_in(beat_in), .bpm_ack(bpm_ack), .bpm(bpm), .bpm_valid(bpm_valid),
    .overrun(overrun), .busy(busy), .too_low(too_low), .too_high(too_high));

  hartslag_sequencer #(.WINDOW_CYCLES(W2), .DEBOUNCE_CYCLES(D), .WIN_SHIFT(SH),
                       .BPM_LOW(LO), .BPM_HIGH(HI)) dut_long (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .cont(cont),
    .beat_in(beat_in), .bpm_ack(bpm_ack), .bpm(bpm2), .bpm_valid(bpm_valid2),
    .overrun(overrun2), .busy(busy2), .too_low(too_low2), .too_high(too_high2));

  int n_checks = 0;
  int n_fail   = 0;

  // reference state: what the consumer should currently see
  bit         m_valid = 1'b0;
  bit         m_over  = 1'b0;
  int         m_bpm   = 0;
  bit         wave [0:2199];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int exp_bpm(input int n);
    return ((n << SH) > 255) ? 255 : (n << SH);
  endfunction

  task automatic clear_wave();
    for (int i = 0; i < 2200; i++) wave[i] = 1'b0;
  endtask

  task automatic add_pulse(inout int t, input int h, input int l);
    for (int k = 0; k < h; k++) wave[t + k] = 1'b1;
    t = t + h + l;
  endtask

  // Pulses of >= D high and >= D low count; glitches shorter than D never do.
  task automatic gen_wave(output int n, input bit glitchy, input int tend);
    int t, h, l, g;
    clear_wave();
    n = 0;
    t = $urandom_range(2, 8);
    while (1) begin
      if (glitchy && $urandom_range(0, 1) == 1) begin
        g = $urandom_range(1, D - 1);
        if (t + g + 4 > tend) break;
        for (int k = 0; k < g; k++) wave[t + k] = 1'b1;
        t = t + g + 4;
      end else begin
        h = $urandom_range(D, 8);
        l = $urandom_range(D + 1, 8);
        if (t + h + l > tend) break;
        add_pulse(t, h, l);
        n++;
      end
    end
  endtask

  task automatic ack_now();
    bpm_ack = 1'b1;
    step();
    bpm_ack = 1'b0;
    m_valid = 1'b0;
    chk("ack_clears_valid", bpm_valid, 0);
  endtask

  task automatic run_single(input int n, input bit ack_rep);
    cont = 1'b0;
    start = 1'b1;
    beat_in = wave[0];
    step();
    start = 1'b0;
    m_over = 1'b0;
    chk("start_busy", busy, 1);
    chk("start_clears_overrun", overrun, 0);
    for (int t = 1; t <= W + 2; t++) begin
      beat_in = wave[t];
      bpm_ack = ack_rep && (t == W + 2);
      step();
      if (t == W + 1) begin
        chk("valid_before_latency", bpm_valid, m_valid);
        chk("bpm_hold_until_report", bpm, m_bpm);
      end
    end
    bpm_ack = 1'b0;
    m_over  = m_valid && !ack_rep;
    m_valid = 1'b1;
    m_bpm   = exp_bpm(n);
    chk("bpm", bpm, m_bpm);
    chk("valid_at_latency", bpm_valid, 1);
    chk("overrun", overrun, m_over);
    chk("busy_after", busy, 0);
    chk("too_low", too_low, ALARM_EN && (m_bpm < LO));
    chk("too_high", too_high, ALARM_EN && (m_bpm > HI));
    beat_in = 1'b0;
    repeat (8) step();
    chk("valid_holds", bpm_valid, 1);
  endtask

  initial begin
    int t, n;
    reset = 1'b1; start = 1'b0; stop = 1'b0; cont = 1'b0; beat_in = 1'b0; bpm_ack = 1'b0;
    repeat (3) step();
    reset = 1'b0;
    step();
    chk("rst_bpm", bpm, 0);
    chk("rst_valid", bpm_valid, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_busy", busy, 0);
    chk("rst_too_low", too_low, 0);
    chk("rst_too_high", too_high, 0);

    // seven clean pulses
    clear_wave();
    t = 3;
    repeat (7) add_pulse(t, 6, 6);
    run_single(7, 1'b0);

    // glitches around three clean pulses
    ack_now();
    clear_wave();
    wave[3] = 1'b1; wave[4] = 1'b1;
    t = 9;
    repeat (3) begin
      add_pulse(t, 6, 6);
      wave[t] = 1'b1; wave[t + 1] = 1'b1;
      t = t + 6;
    end
    run_single(3, 1'b0);

    // randomized trials with random ack behaviour
    for (int i = 0; i < 12; i++) begin
      gen_wave(n, i[0], W - 10);
      if ($urandom_range(0, 1) == 1) ack_now();
      run_single(n, $urandom_range(0, 2) == 0);
    end

    // continuous mode, no ack: 11 then 12 minimum-width pulses
    ack_now();
    clear_wave();
    t = 2;
    repeat (11) add_pulse(t, D, D);
    t = 106;
    repeat (12) add_pulse(t, D, D);
    cont = 1'b1; start = 1'b1; beat_in = wave[0];
    step();
    start = 1'b0; cont = 1'b0;
    for (int k = 1; k <= 2 * (W + 2); k++) begin
      beat_in = wave[k];
      step();
      if (k == W + 2) begin
        chk("cont_bpm1", bpm, exp_bpm(11));
        chk("cont_valid1", bpm_valid, 1);
        chk("cont_overrun1", overrun, 0);
        chk("cont_busy", busy, 1);
        chk("cont_too_high1", too_high, ALARM_EN && (exp_bpm(11) > HI));
      end
      if (k == 2 * (W + 2)) begin
        chk("cont_bpm2", bpm, exp_bpm(12));
        chk("cont_overrun2", overrun, 1);
        chk("cont_too_high2", too_high, ALARM_EN && (exp_bpm(12) > HI));
        chk("cont_too_low2", too_low, 0);
      end
    end
    beat_in = 1'b0;
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("stop_busy", busy, 0);
    chk("overrun_sticky", overrun, 1);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("start_clears_ovr", overrun, 0);
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("stop_keeps_bpm", bpm, exp_bpm(12));
    m_bpm = exp_bpm(12);

    // stop mid-measure, stop beats start, then reset mid-window
    ack_now();
    gen_wave(n, 1'b0, W - 10);
    start = 1'b1; beat_in = wave[0];
    step();
    start = 1'b0;
    for (int k = 1; k <= 51; k++) begin
      beat_in = wave[k];
      stop = (k == 51);
      step();
    end
    stop = 1'b0; beat_in = 1'b0;
    chk("stop_mid_busy", busy, 0);
    stop = 1'b1; start = 1'b1;
    step();
    stop = 1'b0; start = 1'b0;
    chk("stop_wins_busy", busy, 0);
    repeat (W + 10) step();
    chk("stop_no_valid", bpm_valid, 0);
    chk("stop_bpm_unchanged", bpm, m_bpm);
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (40) step();
    reset = 1'b1;
    #1;
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_bpm", bpm, 0);
    chk("rst_mid_valid", bpm_valid, 0);
    chk("rst_mid_overrun", overrun, 0);
    chk("rst_mid_alarm", {too_low, too_high}, 0);
    step();
    reset = 1'b0;
    repeat (W + 10) step();
    chk("rst_no_result", bpm_valid, 0);
    chk("rst_idle", busy, 0);
    m_bpm = 0; m_valid = 1'b0;

    // saturation on the long-window instance
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    clear_wave();
    t = 2;
    repeat (70) add_pulse(t, 5, 5);
    start = 1'b1; beat_in = wave[0];
    step();
    start = 1'b0;
    for (int k = 1; k <= W2 + 2; k++) begin
      beat_in = wave[k];
      step();
      if (k == W2 + 1) chk("sat_valid_before", bpm_valid2, 0);
    end
    chk("sat_bpm", bpm2, 255);
    chk("sat_valid", bpm_valid2, 1);
    chk("sat_too_high", too_high2, ALARM_EN);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
